// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control FSM.
// Drives datapath selects, write enables and memory strobes per state,
// stalls on the memory ready handshake, counts retired instructions and
// parks in HALT on an illegal opcode (or treats it as a NOP).
module mips_multicycle_ctrl #(
  parameter int unsigned CNT_W           = 32,
  parameter bit          HALT_ON_ILLEGAL = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_read,
  output logic             mem_write,
  output logic             iord,
  output logic             ir_write,
  output logic             pc_write,
  output logic [1:0]       pc_src,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic             imm_zext,
  output logic             shamt_sel,
  output logic [2:0]       alu_control,
  output logic [1:0]       reg_dst,
  output logic [1:0]       mem_to_reg,
  output logic             reg_write,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] retired,
  output logic             halted
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_REXEC  = 4'd6,
    S_RWB    = 4'd7,
    S_BRANCH = 4'd8,
    S_IEXEC  = 4'd9,
    S_IWB    = 4'd10,
    S_JUMP   = 4'd11,
    S_JAL    = 4'd12,
    S_JR     = 4'd13,
    S_HALT   = 4'd15
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_SLL   = 6'b000000;
  localparam logic [5:0] FN_JR    = 6'b001000;
  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_SUB   = 6'b100010;
  localparam logic [5:0] FN_AND   = 6'b100100;
  localparam logic [5:0] FN_OR    = 6'b100101;
  localparam logic [5:0] FN_SLT   = 6'b101010;

  localparam logic [2:0] ALU_AND  = 3'b000;
  localparam logic [2:0] ALU_OR   = 3'b001;
  localparam logic [2:0] ALU_ADD  = 3'b010;
  localparam logic [2:0] ALU_SLL  = 3'b011;
  localparam logic [2:0] ALU_SUB  = 3'b110;
  localparam logic [2:0] ALU_SLT  = 3'b111;

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_retired;

  logic       w_mem_read;
  logic       w_mem_write;
  logic       w_iord;
  logic       w_ir_write;
  logic       w_pc_write;
  logic [1:0] w_pc_src;
  logic       w_alu_src_a;
  logic [1:0] w_alu_src_b;
  logic       w_imm_zext;
  logic       w_shamt_sel;
  logic [2:0] w_alu_control;
  logic [1:0] w_reg_dst;
  logic [1:0] w_mem_to_reg;
  logic       w_reg_write;

  // State register and retired-instruction counter (counts every return to FETCH).
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_FETCH;
      r_retired <= '0;
    end else begin
      r_state <= w_next;
      if (w_next == S_FETCH && r_state != S_FETCH)
        r_retired <= r_retired + CNT_W'(1);
    end
  end

  // Next-state and per-state datapath control decode.
  always_comb begin
    w_next        = r_state;
    w_mem_read    = 1'b0;
    w_mem_write   = 1'b0;
    w_iord        = 1'b0;
    w_ir_write    = 1'b0;
    w_pc_write    = 1'b0;
    w_pc_src      = 2'd0;
    w_alu_src_a   = 1'b0;
    w_alu_src_b   = 2'd0;
    w_imm_zext    = 1'b0;
    w_shamt_sel   = 1'b0;
    w_alu_control = ALU_ADD;
    w_reg_dst     = 2'd0;
    w_mem_to_reg  = 2'd0;
    w_reg_write   = 1'b0;

    case (r_state)
      S_FETCH: begin
        w_mem_read  = 1'b1;
        w_alu_src_b = 2'd1;
        w_ir_write  = mem_ready;
        w_pc_write  = mem_ready;
        w_next      = mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        w_alu_src_b = 2'd3;
        case (opcode)
          OP_LW, OP_SW:   w_next = S_MEMADR;
          OP_RTYPE:       w_next = (funct == FN_JR) ? S_JR : S_REXEC;
          OP_BEQ, OP_BNE: w_next = S_BRANCH;
          OP_ADDI, OP_ANDI: w_next = S_IEXEC;
          OP_J:           w_next = S_JUMP;
          OP_JAL:         w_next = S_JAL;
          default:        w_next = HALT_ON_ILLEGAL ? S_HALT : S_FETCH;
        endcase
      end
      S_MEMADR: begin
        w_alu_src_a = 1'b1;
        w_alu_src_b = 2'd2;
        w_next      = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        w_iord     = 1'b1;
        w_mem_read = 1'b1;
        w_next     = mem_ready ? S_MEMWB : S_MEMRD;
      end
      S_MEMWB: begin
        w_mem_to_reg = 2'd1;
        w_reg_write  = 1'b1;
        w_next       = S_FETCH;
      end
      S_MEMWR: begin
        w_iord      = 1'b1;
        w_mem_write = 1'b1;
        w_next      = mem_ready ? S_FETCH : S_MEMWR;
      end
      S_REXEC: begin
        w_alu_src_a = 1'b1;
        case (funct)
          FN_ADD: w_alu_control = ALU_ADD;
          FN_SUB: w_alu_control = ALU_SUB;
          FN_AND: w_alu_control = ALU_AND;
          FN_OR:  w_alu_control = ALU_OR;
          FN_SLT: w_alu_control = ALU_SLT;
          FN_SLL: begin
            w_alu_control = ALU_SLL;
            w_shamt_sel   = 1'b1;
          end
          default: w_alu_control = ALU_ADD;
        endcase
        w_next = S_RWB;
      end
      S_RWB: begin
        w_reg_dst   = 2'd1;
        w_reg_write = 1'b1;
        w_next      = S_FETCH;
      end
      S_BRANCH: begin
        w_alu_src_a   = 1'b1;
        w_alu_control = ALU_SUB;
        w_pc_src      = 2'd1;
        w_pc_write    = ((opcode == OP_BEQ) & zero) | ((opcode == OP_BNE) & ~zero);
        w_next        = S_FETCH;
      end
      S_IEXEC: begin
        w_alu_src_a   = 1'b1;
        w_alu_src_b   = 2'd2;
        w_imm_zext    = (opcode == OP_ANDI);
        w_alu_control = (opcode == OP_ANDI) ? ALU_AND : ALU_ADD;
        w_next        = S_IWB;
      end
      S_IWB: begin
        w_reg_write = 1'b1;
        w_next      = S_FETCH;
      end
      S_JUMP: begin
        w_pc_src   = 2'd2;
        w_pc_write = 1'b1;
        w_next     = S_FETCH;
      end
      S_JAL: begin
        w_pc_src     = 2'd2;
        w_pc_write   = 1'b1;
        w_reg_dst    = 2'd2;
        w_mem_to_reg = 2'd2;
        w_reg_write  = 1'b1;
        w_next       = S_FETCH;
      end
      S_JR: begin
        w_pc_src   = 2'd3;
        w_pc_write = 1'b1;
        w_next     = S_FETCH;
      end
      S_HALT: begin
        w_next = S_HALT;
      end
      default: begin
        w_next = S_FETCH;
      end
    endcase
  end

  // Every control output is forced low during reset, so an instruction
  // interrupted by reset cannot write memory, registers or the PC.
  assign mem_read    = w_mem_read  & ~reset;
  assign mem_write   = w_mem_write & ~reset;
  assign iord        = w_iord      & ~reset;
  assign ir_write    = w_ir_write  & ~reset;
  assign pc_write    = w_pc_write  & ~reset;
  assign pc_src      = reset ? '0 : w_pc_src;
  assign alu_src_a   = w_alu_src_a & ~reset;
  assign alu_src_b   = reset ? '0 : w_alu_src_b;
  assign imm_zext    = w_imm_zext  & ~reset;
  assign shamt_sel   = w_shamt_sel & ~reset;
  assign alu_control = reset ? '0 : w_alu_control;
  assign reg_dst     = reset ? '0 : w_reg_dst;
  assign mem_to_reg  = reset ? '0 : w_mem_to_reg;
  assign reg_write   = w_reg_write & ~reset;
  assign state       = reset ? '0 : r_state;
  assign retired     = r_retired;
  assign halted      = ~reset & (r_state == S_HALT);

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Bench for mips_multicycle_ctrl: table of zero-wait instructions with
// per-cycle expected state/control, plus hand-written stall, halt, NOP
// and reset-mid-instruction sequences.
module tb_mips_multicycle_ctrl;

  typedef struct packed {
    logic       mr;
    logic       mw;
    logic       iord;
    logic       irw;
    logic       pcw;
    logic [1:0] pcsrc;
    logic       asa;
    logic [1:0] asb;
    logic       zext;
    logic       sh;
    logic [2:0] alu;
    logic [1:0] rd;
    logic [1:0] m2r;
    logic       rw;
  } ctrl_t;

  typedef struct {
    string         name;
    logic [5:0]    op;
    logic [5:0]    fn;
    logic          z;
    int unsigned   n;
    logic [4:0][3:0] st;
    ctrl_t [4:0]   c;
  } vec_t;

  typedef struct {
    string      name;
    logic [3:0] st;
    ctrl_t      c;
    logic       h;
  } exp_t;

  localparam logic [2:0] A_AND = 3'b000;
  localparam logic [2:0] A_OR  = 3'b001;
  localparam logic [2:0] A_ADD = 3'b010;
  localparam logic [2:0] A_SLL = 3'b011;
  localparam logic [2:0] A_SUB = 3'b110;
  localparam logic [2:0] A_SLT = 3'b111;

  localparam ctrl_t C_RST    = '0;
  localparam ctrl_t C_FETCH  = '{mr:1'b1, irw:1'b1, pcw:1'b1, asb:2'd1, alu:A_ADD, default:'0};
  localparam ctrl_t C_FSTALL = '{mr:1'b1, asb:2'd1, alu:A_ADD, default:'0};
  localparam ctrl_t C_DEC    = '{asb:2'd3, alu:A_ADD, default:'0};
  localparam ctrl_t C_MADR   = '{asa:1'b1, asb:2'd2, alu:A_ADD, default:'0};
  localparam ctrl_t C_MRD    = '{iord:1'b1, mr:1'b1, alu:A_ADD, default:'0};
  localparam ctrl_t C_MWB    = '{m2r:2'd1, rw:1'b1, alu:A_ADD, default:'0};
  localparam ctrl_t C_MWR    = '{iord:1'b1, mw:1'b1, alu:A_ADD, default:'0};
  localparam ctrl_t C_RWB    = '{rd:2'd1, rw:1'b1, alu:A_ADD, default:'0};
  localparam ctrl_t C_IWB    = '{rw:1'b1, alu:A_ADD, default:'0};
  localparam ctrl_t C_J      = '{pcsrc:2'd2, pcw:1'b1, alu:A_ADD, default:'0};
  localparam ctrl_t C_JAL    = '{pcsrc:2'd2, pcw:1'b1, rd:2'd2, m2r:2'd2, rw:1'b1, alu:A_ADD, default:'0};
  localparam ctrl_t C_JR     = '{pcsrc:2'd3, pcw:1'b1, alu:A_ADD, default:'0};
  localparam ctrl_t C_HALT   = '{alu:A_ADD, default:'0};

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic        zero;
  logic        mem_ready;

  logic        mem_read, mem_write, iord, ir_write, pc_write;
  logic [1:0]  pc_src;
  logic        alu_src_a;
  logic [1:0]  alu_src_b;
  logic        imm_zext, shamt_sel;
  logic [2:0]  alu_control;
  logic [1:0]  reg_dst, mem_to_reg;
  logic        reg_write;
  logic [3:0]  state;
  logic [31:0] retired;
  logic        halted;

  logic        n_mem_read, n_mem_write, n_iord, n_ir_write, n_pc_write;
  logic [1:0]  n_pc_src;
  logic        n_alu_src_a;
  logic [1:0]  n_alu_src_b;
  logic        n_imm_zext, n_shamt_sel;
  logic [2:0]  n_alu_control;
  logic [1:0]  n_reg_dst, n_mem_to_reg;
  logic        n_reg_write;
  logic [3:0]  n_state;
  logic [31:0] n_retired;
  logic        n_halted;

  ctrl_t act;
  assign act = {mem_read, mem_write, iord, ir_write, pc_write, pc_src, alu_src_a,
                alu_src_b, imm_zext, shamt_sel, alu_control, reg_dst, mem_to_reg, reg_write};

  mips_multicycle_ctrl #(.CNT_W(32), .HALT_ON_ILLEGAL(1'b1)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .mem_read(mem_read), .mem_write(mem_write), .iord(iord),
    .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .imm_zext(imm_zext), .shamt_sel(shamt_sel),
    .alu_control(alu_control), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .reg_write(reg_write), .state(state), .retired(retired), .halted(halted)
  );

  mips_multicycle_ctrl #(.CNT_W(32), .HALT_ON_ILLEGAL(1'b0)) dut_nop (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .mem_read(n_mem_read), .mem_write(n_mem_write), .iord(n_iord),
    .ir_write(n_ir_write), .pc_write(n_pc_write), .pc_src(n_pc_src), .alu_src_a(n_alu_src_a),
    .alu_src_b(n_alu_src_b), .imm_zext(n_imm_zext), .shamt_sel(n_shamt_sel),
    .alu_control(n_alu_control), .reg_dst(n_reg_dst), .mem_to_reg(n_mem_to_reg),
    .reg_write(n_reg_write), .state(n_state), .retired(n_retired), .halted(n_halted)
  );

  always #5 clk = ~clk;

  int unsigned tests = 0;
  int unsigned fails = 0;
  int unsigned exp_ret = 0;
  exp_t sb[$];
  vec_t vtab[$];

  function automatic ctrl_t rexec(input logic [2:0] a, input logic s);
    ctrl_t c;
    c = '0;
    c.asa = 1'b1;
    c.alu = a;
    c.sh  = s;
    return c;
  endfunction

  function automatic ctrl_t branch(input logic w);
    ctrl_t c;
    c = '0;
    c.asa   = 1'b1;
    c.alu   = A_SUB;
    c.pcsrc = 2'd1;
    c.pcw   = w;
    return c;
  endfunction

  function automatic ctrl_t iexec(input logic zx, input logic [2:0] a);
    ctrl_t c;
    c = '0;
    c.asa  = 1'b1;
    c.asb  = 2'd2;
    c.zext = zx;
    c.alu  = a;
    return c;
  endfunction

  function automatic void addv(input string nm, input logic [5:0] op, input logic [5:0] fn,
                               input logic z, input int unsigned n,
                               input logic [3:0] s0, input logic [3:0] s1, input logic [3:0] s2,
                               input logic [3:0] s3, input logic [3:0] s4,
                               input ctrl_t c0, input ctrl_t c1, input ctrl_t c2,
                               input ctrl_t c3, input ctrl_t c4);
    vec_t v;
    v.name = nm; v.op = op; v.fn = fn; v.z = z; v.n = n;
    v.st[0] = s0; v.st[1] = s1; v.st[2] = s2; v.st[3] = s3; v.st[4] = s4;
    v.c[0] = c0;  v.c[1] = c1;  v.c[2] = c2;  v.c[3] = c3;  v.c[4] = c4;
    vtab.push_back(v);
  endfunction

  // One clock: drive inputs, queue the expectation, compare at the falling edge.
  task automatic cyc(input logic rst, input logic mr, input logic z, input logic [3:0] es,
                     input ctrl_t ec, input logic eh, input string nm);
    exp_t e;
    reset = rst;
    mem_ready = mr;
    zero = z;
    e.name = nm; e.st = es; e.c = ec; e.h = eh;
    sb.push_back(e);
    @(negedge clk);
    e = sb.pop_front();
    tests++;
    if (state !== e.st || act !== e.c || halted !== e.h) begin
      fails++;
      $display("FAIL %s: got state=%0d ctrl=%h halted=%b, want state=%0d ctrl=%h halted=%b",
               e.name, state, act, halted, e.st, e.c, e.h);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %0d, want %0d", nm, got, want);
    end
  endtask

  initial begin
    reset = 1'b1; mem_ready = 1'b0; zero = 1'b0; opcode = '0; funct = '0;

    addv("add",  6'h00, 6'b100000, 0, 4, 0, 1, 6, 7, 0, C_FETCH, C_DEC, rexec(A_ADD, 0), C_RWB, C_RST);
    addv("sub",  6'h00, 6'b100010, 0, 4, 0, 1, 6, 7, 0, C_FETCH, C_DEC, rexec(A_SUB, 0), C_RWB, C_RST);
    addv("and",  6'h00, 6'b100100, 0, 4, 0, 1, 6, 7, 0, C_FETCH, C_DEC, rexec(A_AND, 0), C_RWB, C_RST);
    addv("or",   6'h00, 6'b100101, 0, 4, 0, 1, 6, 7, 0, C_FETCH, C_DEC, rexec(A_OR, 0),  C_RWB, C_RST);
    addv("slt",  6'h00, 6'b101010, 0, 4, 0, 1, 6, 7, 0, C_FETCH, C_DEC, rexec(A_SLT, 0), C_RWB, C_RST);
    addv("sll",  6'h00, 6'b000000, 0, 4, 0, 1, 6, 7, 0, C_FETCH, C_DEC, rexec(A_SLL, 1), C_RWB, C_RST);
    addv("addu", 6'h00, 6'b100001, 0, 4, 0, 1, 6, 7, 0, C_FETCH, C_DEC, rexec(A_ADD, 0), C_RWB, C_RST);
    addv("jr",   6'h00, 6'b001000, 0, 3, 0, 1, 13, 0, 0, C_FETCH, C_DEC, C_JR, C_RST, C_RST);
    addv("lw",   6'h23, 6'h00, 0, 5, 0, 1, 2, 3, 4, C_FETCH, C_DEC, C_MADR, C_MRD, C_MWB);
    addv("sw",   6'h2b, 6'h00, 0, 4, 0, 1, 2, 5, 0, C_FETCH, C_DEC, C_MADR, C_MWR, C_RST);
    addv("beq_z1", 6'h04, 6'h00, 1, 3, 0, 1, 8, 0, 0, C_FETCH, C_DEC, branch(1), C_RST, C_RST);
    addv("beq_z0", 6'h04, 6'h00, 0, 3, 0, 1, 8, 0, 0, C_FETCH, C_DEC, branch(0), C_RST, C_RST);
    addv("bne_z1", 6'h05, 6'h00, 1, 3, 0, 1, 8, 0, 0, C_FETCH, C_DEC, branch(0), C_RST, C_RST);
    addv("bne_z0", 6'h05, 6'h00, 0, 3, 0, 1, 8, 0, 0, C_FETCH, C_DEC, branch(1), C_RST, C_RST);
    addv("addi", 6'h08, 6'h00, 0, 4, 0, 1, 9, 10, 0, C_FETCH, C_DEC, iexec(0, A_ADD), C_IWB, C_RST);
    addv("andi", 6'h0c, 6'h00, 0, 4, 0, 1, 9, 10, 0, C_FETCH, C_DEC, iexec(1, A_AND), C_IWB, C_RST);
    addv("j",    6'h02, 6'h00, 0, 3, 0, 1, 11, 0, 0, C_FETCH, C_DEC, C_J, C_RST, C_RST);
    addv("jal",  6'h03, 6'h00, 0, 3, 0, 1, 12, 0, 0, C_FETCH, C_DEC, C_JAL, C_RST, C_RST);

    @(posedge clk);
    #1;
    cyc(1, 0, 0, 4'd0, C_RST, 0, "reset_c0");
    cyc(1, 0, 0, 4'd0, C_RST, 0, "reset_c1");
    chk("retired_after_reset", retired, 0);

    foreach (vtab[i]) begin
      opcode = vtab[i].op;
      funct  = vtab[i].fn;
      chk({vtab[i].name, "_retired_before"}, retired, exp_ret);
      for (int unsigned k = 0; k < vtab[i].n; k++)
        cyc(0, 1, vtab[i].z, vtab[i].st[k], vtab[i].c[k], 0, $sformatf("%s_c%0d", vtab[i].name, k));
      exp_ret++;
    end
    chk("retired_after_table", retired, exp_ret);

    // lw with three FETCH wait cycles and two MEMRD wait cycles: 10 cycles.
    opcode = 6'h23; funct = '0;
    for (int unsigned k = 0; k < 3; k++) cyc(0, 0, 0, 4'd0, C_FSTALL, 0, "lw_fetch_wait");
    cyc(0, 1, 0, 4'd0, C_FETCH, 0, "lw_fetch_ready");
    cyc(0, 1, 0, 4'd1, C_DEC, 0, "lw_decode");
    cyc(0, 1, 0, 4'd2, C_MADR, 0, "lw_memadr");
    for (int unsigned k = 0; k < 2; k++) cyc(0, 0, 0, 4'd3, C_MRD, 0, "lw_memrd_wait");
    cyc(0, 1, 0, 4'd3, C_MRD, 0, "lw_memrd_ready");
    cyc(0, 1, 0, 4'd4, C_MWB, 0, "lw_memwb");
    exp_ret++;
    chk("lw_stall_retired", retired, exp_ret);
    chk("nop_inst_retired_sync", n_retired, exp_ret);

    // Illegal opcode: main instance halts, NOP instance retires and refetches.
    opcode = 6'b111111;
    cyc(0, 1, 0, 4'd0, C_FETCH, 0, "ill_fetch");
    cyc(0, 1, 0, 4'd1, C_DEC, 0, "ill_decode");
    chk("nop_inst_state_fetch", {28'd0, n_state}, 0);
    chk("nop_inst_retired_inc", n_retired, exp_ret + 1);
    for (int unsigned k = 0; k < 20; k++) cyc(0, 1, 0, 4'd15, C_HALT, 1, "halt_hold");
    chk("halt_retired_unchanged", retired, exp_ret);
    cyc(1, 1, 0, 4'd0, C_RST, 0, "halt_reset");
    chk("halt_reset_retired", retired, 0);
    chk("halt_reset_nop_retired", n_retired, 0);

    // Reset asserted while in MEMWR with the store still pending.
    opcode = 6'h2b;
    cyc(0, 1, 0, 4'd0, C_FETCH, 0, "swr_fetch");
    cyc(0, 1, 0, 4'd1, C_DEC, 0, "swr_decode");
    cyc(0, 1, 0, 4'd2, C_MADR, 0, "swr_memadr");
    cyc(1, 0, 0, 4'd0, C_RST, 0, "swr_reset_in_memwr");
    chk("swr_retired_after_reset", retired, 0);
    cyc(0, 1, 0, 4'd0, C_FETCH, 0, "swr_fetch_after_reset");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
